vic_host_bridge: RTL and testbench
==================================

# vic_host_bridge

Byte-wide host bus front end for `vic_registers`. It accepts 8-bit register reads and writes from the host/CPU side into a small request FIFO. Each request is serialized into two nibble accesses on the `vic_registers` port (`i_VIC_regaddr`, `i_VIC_data`, `i_VIC_we`, `i_VIC_re`, `o_VIC_data`). Read nibbles are reassembled into a byte with a one-cycle valid strobe.

## Interface
- `FIFO_DEPTH`, default 4: request FIFO entries; power of 2, ≥2.
- One clock; reset is asynchronous and active-low.
- `i_clk` in 1: clock; all state on rising edge.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_addr` in 4: host byte register address (0–15).
- `i_wdata` in 8: host write data.
- `i_wr` in 1: write request strobe, one cycle per request.
- `i_rd` in 1: read request strobe, one cycle per request.
- `o_rdata` in/out? No — `o_rdata` out 8: read result, held until the next read completes.
- `o_rvalid` out 1: one-cycle pulse when `o_rdata` is updated.
- `o_full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `o_busy` out 1: FIFO not empty or FSM not IDLE.
- `o_ovf` out 1: one-cycle pulse; a request was dropped because the FIFO was full.
- `o_err` out 1: one-cycle pulse; `i_wr` and `i_rd` were both high.
- `o_VIC_regaddr` out 5: nibble address to `vic_registers`.
- `o_VIC_data` out 4: nibble write data.
- `o_VIC_we` out 1: nibble write enable.
- `o_VIC_re` out 1: nibble read enable.
- `i_VIC_data` in 4: nibble read data from `vic_registers`. It is valid the cycle after `o_VIC_re` is sampled high.

## Operation
- **Address mapping:** byte A maps to two nibbles.
  - Low nibble at `{A,1'b0}`.
  - High nibble at `{A,1'b1}`.
- **FIFO entry format:** `{is_rd, addr[3:0], data[7:0]}`, 13 bits. Read entries carry don't-care data.
- **Push rules:**
  - Push on `i_wr` or `i_rd` if not full. Fullness is evaluated on the registered state at the start of the cycle; a same-cycle pop does not free a slot.
  - `i_wr` and `i_rd` both high: the write is enqueued, the read is discarded, and `o_err` pulses.
  - Push while full: the request is dropped and `o_ovf` pulses the next cycle. If `o_err` also applies, both pulse.
- **FSM states:** IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_CAP.
  - IDLE: if the FIFO is non-empty, pop into a command register and go to WR_LO or RD_LO. Otherwise stay in IDLE.
  - WR_LO: `o_VIC_we`=1, addr `{A,0}`, data `wdata[3:0]`. Next state WR_HI.
  - WR_HI: `o_VIC_we`=1, addr `{A,1}`, data `wdata[7:4]`. Next state IDLE.
  - RD_LO: `o_VIC_re`=1, addr `{A,0}`. Next state RD_HI.
  - RD_HI: `o_VIC_re`=1, addr `{A,1}`; capture `i_VIC_data` into the low-nibble register. Next state RD_CAP.
  - RD_CAP: `o_rdata` <= `{i_VIC_data, lo}` and `o_rvalid` <= 1 at the end of the cycle. Next state IDLE.
- Register-side outputs are decoded from the state and command registers only. Outside the write and read states they are all 0.
- Requests execute strictly in FIFO order, so read-after-write returns the written value.
- **Reset:** asynchronous. It empties the FIFO, forces IDLE, and clears `o_rdata`, `o_rvalid`, `o_ovf`, `o_err`, `o_full`, `o_busy`, and all `o_VIC_*` outputs to 0 immediately.
  - A half-finished write (low nibble only) is abandoned and never completed.
  - A pending read produces no `o_rvalid`.

## Timing
- Edge numbering: request sampled at edge 0, FIFO empty, FSM in IDLE.
  - Write: pop at edge 1; WR_LO during cycle 1–2; WR_HI during cycle 2–3; back in IDLE after edge 3.
  - Read: pop at edge 1; RD_LO cycle 1–2; RD_HI cycle 2–3; RD_CAP cycle 3–4; `o_rvalid` high during cycle 4–5.
- Throughput: 3 cycles per write, 4 per read. IDLE always costs one cycle.
- `o_full` and `o_busy` are registered, updated the same edge as the push or pop.

## Test plan
- Write A=3, data 0xA5 → cycle 1: `we`=1, regaddr 6, data 0x5. Cycle 2: `we`=1, regaddr 7, data 0xA. Then `o_busy`=0 after edge 3.
- After that write, read A=3 against a `vic_registers` model → `o_rvalid` pulses at cycle 4 with `o_rdata`=0xA5. `re` is high for regaddr 6 then 7.
- Seven back-to-back writes with `FIFO_DEPTH`=4:
  - `o_full` is high after edge 5.
  - The 7th write is dropped and `o_ovf` pulses.
  - The first six appear in order on the `we` port.
- `i_wr`=`i_rd`=1 with A=1, data 0x3C → only writes to regaddr 2/3 occur, `o_err` pulses once, and no `o_rvalid`.
- `i_rst_n` low during WR_HI of a queued write plus two pending requests → all outputs 0 immediately. After release there is no bus activity until new requests arrive.
- Write 0x0F to A=15, then read A=15 → regaddr 30/31 used, no wrap, `o_rdata`=0x0F.

Source files
------------

// File: rtl/vic_host_bridge.sv
// Byte-wide host front end for vic_registers: queues byte reads/writes in a small
// FIFO and serializes each one into a low-nibble then high-nibble register access.
module vic_host_bridge #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_addr,
    input  logic [7:0] i_wdata,
    input  logic       i_wr,
    input  logic       i_rd,
    output logic [7:0] o_rdata,
    output logic       o_rvalid,
    output logic       o_full,
    output logic       o_busy,
    output logic       o_ovf,
    output logic       o_err,
    output logic [4:0] o_VIC_regaddr,
    output logic [3:0] o_VIC_data,
    output logic       o_VIC_we,
    output logic       o_VIC_re,
    input  logic [3:0] i_VIC_data,
    output logic [2:0] o_dbg_state
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_LO  = 3'd1,
        WR_HI  = 3'd2,
        RD_LO  = 3'd3,
        RD_HI  = 3'd4,
        RD_CAP = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [12:0]   mem [FIFO_DEPTH];
    logic [12:0]   head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic [11:0]   cmd;
    logic [3:0]    lo_nib;
    logic          req, fifo_full, push, pop;

    // Handshake: a request is a one-cycle i_wr/i_rd strobe; it is taken when the
    // FIFO was not full at the start of the cycle, otherwise dropped and flagged.
    assign req       = i_wr | i_rd;
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign push      = req & ~fifo_full;
    assign pop       = (state == IDLE) && (count != '0);
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign head      = mem[rd_ptr];
    assign o_dbg_state = state;

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= {i_rd & ~i_wr, i_addr, i_wdata};
    end

    always_comb begin
        state_nxt     = state;
        o_VIC_we      = 1'b0;
        o_VIC_re      = 1'b0;
        o_VIC_regaddr = 5'd0;
        o_VIC_data    = 4'd0;
        case (state)
            IDLE:   if (pop) state_nxt = head[12] ? RD_LO : WR_LO;
            WR_LO: begin
                o_VIC_we      = 1'b1;
                o_VIC_regaddr = {cmd[11:8], 1'b0};
                o_VIC_data    = cmd[3:0];
                state_nxt     = WR_HI;
            end
            WR_HI: begin
                o_VIC_we      = 1'b1;
                o_VIC_regaddr = {cmd[11:8], 1'b1};
                o_VIC_data    = cmd[7:4];
                state_nxt     = IDLE;
            end
            RD_LO: begin
                o_VIC_re      = 1'b1;
                o_VIC_regaddr = {cmd[11:8], 1'b0};
                state_nxt     = RD_HI;
            end
            RD_HI: begin
                o_VIC_re      = 1'b1;
                o_VIC_regaddr = {cmd[11:8], 1'b1};
                state_nxt     = RD_CAP;
            end
            RD_CAP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read nibbles arrive one cycle after their re, hence capture in RD_HI/RD_CAP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cmd      <= '0;
            lo_nib   <= '0;
            o_rdata  <= '0;
            o_rvalid <= 1'b0;
            o_full   <= 1'b0;
            o_busy   <= 1'b0;
            o_ovf    <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            o_full   <= (count_nxt == CW'(FIFO_DEPTH));
            o_busy   <= (count_nxt != '0) || (state_nxt != IDLE);
            o_ovf    <= req & fifo_full;
            o_err    <= i_wr & i_rd;
            o_rvalid <= (state == RD_CAP);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                cmd    <= head[11:0];
            end
            if (state == RD_HI) lo_nib <= i_VIC_data;
            if (state == RD_CAP) o_rdata <= {i_VIC_data, lo_nib};
        end
    end
endmodule

// File: tb/tb_vic_host_bridge.sv
// Randomized bench for vic_host_bridge: a queueing-level reference model predicts
// drops, fullness, busy and the exact nibble traffic; a negedge monitor checks it.
module tb_vic_host_bridge;
    localparam int DEPTH = 4;
    localparam int MAXE  = 8192;
    localparam int MAXN  = 2048;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] i_addr = 4'd0;
    logic [7:0] i_wdata = 8'd0;
    logic       i_wr = 1'b0, i_rd = 1'b0;
    logic [7:0] o_rdata;
    logic       o_rvalid, o_full, o_busy, o_ovf, o_err;
    logic [4:0] o_VIC_regaddr;
    logic [3:0] o_VIC_data;
    logic       o_VIC_we, o_VIC_re;
    logic [3:0] vic_rdata = 4'd0;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    vic_host_bridge #(.FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_wr(i_wr), .i_rd(i_rd), .o_rdata(o_rdata), .o_rvalid(o_rvalid),
        .o_full(o_full), .o_busy(o_busy), .o_ovf(o_ovf), .o_err(o_err),
        .o_VIC_regaddr(o_VIC_regaddr), .o_VIC_data(o_VIC_data),
        .o_VIC_we(o_VIC_we), .o_VIC_re(o_VIC_re), .i_VIC_data(vic_rdata),
        .o_dbg_state(dbg_state)
    );

    // Nibble register file on the far side of the bridge.
    logic [3:0] nib [32] = '{default: 4'h0};
    always @(posedge clk) begin
        if (o_VIC_we) nib[o_VIC_regaddr] <= o_VIC_data;
        if (o_VIC_re) vic_rdata <= nib[o_VIC_regaddr];
    end

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Reference model: FIFO of requests served one at a time, 3 cycles per write, 4 per read.
    int         push_e [MAXN];
    int         pop_e  [MAXN];
    int         cost_e [MAXN];
    int         n_ent = 0, live_base = 0, free_e = 0;
    bit         exp_ovf_a [MAXE];
    bit         exp_err_a [MAXE];
    logic [7:0] ref_mem [16] = '{default: 8'h00};
    logic [26:0] bus_q [$];   // {edge, we, re, regaddr, wdata}
    logic [23:0] rd_q  [$];   // {edge, rdata}
    int         n_checks = 0, n_fail = 0;
    bit         mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at edge %0d", name, edge_n);
    endtask

    function automatic int occ_before(input int t);
        int n = 0;
        for (int i = live_base; i < n_ent; i++)
            if (push_e[i] < t && pop_e[i] >= t) n++;
        return n;
    endfunction

    function automatic bit full_after(input int t);
        int n = 0;
        for (int i = live_base; i < n_ent; i++)
            if (push_e[i] <= t && pop_e[i] > t) n++;
        return n == DEPTH;
    endfunction

    function automatic bit busy_after(input int t);
        bit b = 1'b0;
        for (int i = live_base; i < n_ent; i++) begin
            if (push_e[i] <= t && pop_e[i] > t) b = 1'b1;
            if (pop_e[i] <= t && t < pop_e[i] + cost_e[i] - 1) b = 1'b1;
        end
        return b;
    endfunction

    task automatic cycle(input logic wr, input logic rd, input logic [3:0] a, input logic [7:0] d);
        int t, p;
        bit is_rd;
        @(negedge clk);
        #1;
        i_wr = wr; i_rd = rd; i_addr = a; i_wdata = d;
        t = edge_n + 1;
        exp_err_a[t] = wr & rd;
        if (wr | rd) begin
            if (occ_before(t) >= DEPTH) begin
                exp_ovf_a[t] = 1'b1;
            end else begin
                is_rd = rd & ~wr;
                p = (t + 1 > free_e) ? t + 1 : free_e;
                push_e[n_ent] = t;
                pop_e[n_ent]  = p;
                cost_e[n_ent] = is_rd ? 4 : 3;
                n_ent++;
                free_e = p + (is_rd ? 4 : 3);
                if (is_rd) begin
                    bus_q.push_back({16'(p), 2'b01, a, 1'b0, 4'h0});
                    bus_q.push_back({16'(p + 1), 2'b01, a, 1'b1, 4'h0});
                    rd_q.push_back({16'(p + 3), ref_mem[a]});
                end else begin
                    bus_q.push_back({16'(p), 2'b10, a, 1'b0, d[3:0]});
                    bus_q.push_back({16'(p + 1), 2'b10, a, 1'b1, d[7:4]});
                    ref_mem[a] = d;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    // Monitor: per-edge flags against the model, and bus/read traffic against the queues.
    always @(negedge clk) begin : mon
        logic [26:0] be;
        logic [23:0] re;
        if (mon_on && rst_n) begin
            chk("ovf", {31'd0, o_ovf}, {31'd0, exp_ovf_a[edge_n]});
            chk("err", {31'd0, o_err}, {31'd0, exp_err_a[edge_n]});
            chk("full", {31'd0, o_full}, {31'd0, full_after(edge_n)});
            chk("busy", {31'd0, o_busy}, {31'd0, busy_after(edge_n)});
            if (o_VIC_we || o_VIC_re) begin
                if (bus_q.size() == 0) fail_now("bus_unexpected");
                else begin
                    be = bus_q.pop_front();
                    chk("bus_edge", edge_n, {16'd0, be[26:11]});
                    chk("bus_ctl", {25'd0, o_VIC_we, o_VIC_re, o_VIC_regaddr}, {25'd0, be[10:4]});
                    if (o_VIC_we) chk("bus_wdata", {28'd0, o_VIC_data}, {28'd0, be[3:0]});
                end
            end else if (bus_q.size() != 0 && {16'd0, bus_q[0][26:11]} <= edge_n) begin
                fail_now("bus_missing");
                void'(bus_q.pop_front());
            end
            if (o_rvalid) begin
                if (rd_q.size() == 0) fail_now("rvalid_unexpected");
                else begin
                    re = rd_q.pop_front();
                    chk("rvalid_edge", edge_n, {16'd0, re[23:8]});
                    chk("rdata", {24'd0, o_rdata}, {24'd0, re[7:0]});
                end
            end else if (rd_q.size() != 0 && {16'd0, rd_q[0][23:8]} <= edge_n) begin
                fail_now("rvalid_missing");
                void'(rd_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] old5;
        int k;
        repeat (2) @(negedge clk);
        chk("rst_flags", {27'd0, o_rvalid, o_full, o_busy, o_ovf, o_err}, 32'd0);
        chk("rst_rdata", {24'd0, o_rdata}, 32'd0);
        chk("rst_vic", {21'd0, o_VIC_we, o_VIC_re, o_VIC_regaddr, o_VIC_data}, 32'd0);
        #1 rst_n = 1'b1;
        mon_on = 1'b1;
        idle(2);

        cycle(1'b1, 1'b0, 4'd3, 8'hA5); idle(6);
        cycle(1'b0, 1'b1, 4'd3, 8'h00); idle(7);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 4'(i + 4), 8'($urandom_range(0, 255)));
        idle(25);
        cycle(1'b1, 1'b1, 4'd1, 8'h3C); idle(6);
        cycle(1'b0, 1'b1, 4'd1, 8'h00); idle(7);
        cycle(1'b1, 1'b0, 4'd15, 8'h0F); idle(4);
        cycle(1'b0, 1'b1, 4'd15, 8'h00); idle(7);

        // Reset in the middle of WR_HI with two reads still queued.
        old5 = ref_mem[5];
        cycle(1'b1, 1'b0, 4'd5, 8'h96);
        cycle(1'b0, 1'b1, 4'd5, 8'h00);
        cycle(1'b0, 1'b1, 4'd9, 8'h00);
        @(negedge clk);
        #1;
        i_wr = 1'b0; i_rd = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_flags", {27'd0, o_rvalid, o_full, o_busy, o_ovf, o_err}, 32'd0);
        chk("arst_rdata", {24'd0, o_rdata}, 32'd0);
        chk("arst_vic", {21'd0, o_VIC_we, o_VIC_re, o_VIC_regaddr, o_VIC_data}, 32'd0);
        bus_q.delete();
        rd_q.delete();
        live_base = n_ent;
        free_e = 0;
        ref_mem[5] = {old5[7:4], 4'h6};
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        idle(10);
        cycle(1'b0, 1'b1, 4'd5, 8'h00); idle(7);

        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            cycle(k <= 4 || k == 9, k >= 5, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            idle($urandom_range(0, 3));
        end
        idle(1);

        k = 0;
        while (k < 400 && (bus_q.size() != 0 || rd_q.size() != 0)) begin
            @(negedge clk);
            k++;
        end
        if (bus_q.size() != 0 || rd_q.size() != 0) fail_now("drain_timeout");
        idle(3);
        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
